// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 sequential core controller:
// architectural status codes, opcode constants and sequencer states.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } seq_state_t;

  // Opcodes that touch data memory and therefore need the MEMORY stage.
  function automatic logic needs_mem(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
           (ic == I_RET)    || (ic == I_PUSHQ)  || (ic == I_POPQ);
  endfunction

endpackage

// File: rtl/y86_ack_timer.sv
// Down-counter bounding how long the sequencer waits for a memory ack;
// reloaded while no request is outstanding, flags the last allowed cycle.
module y86_ack_timer
  import y86_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CW'(TIMEOUT);
    end else if (load) begin
      cnt <= CW'(TIMEOUT);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == CW'(1));

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle stage sequencer: steps each instruction through the six stages,
// owns the imem/dmem handshakes, tracks status and counts retirements.
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic             imem_err,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  output logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             dmem_err,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic             pc_we,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  seq_state_t state;
  logic [3:0] icode_q;
  logic       tmo;

  // FETCH and MEMORY are never back to back, so reloading whenever no request
  // is outstanding gives every wait a fresh budget from its first cycle.
  y86_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (!(imem_req || dmem_req)),
    .dec     ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)),
    .expired (tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      icode_q   <= I_HALT;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      wb_en     <= 1'b0;
      pc_we     <= 1'b0;
      stat      <= STAT_AOK;
      busy      <= 1'b0;
      retired   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (imem_err || !instr_valid || (icode == I_HALT)) begin
              state <= S_HALT;
              busy  <= 1'b0;
              if (imem_err)           stat <= STAT_ADR;
              else if (!instr_valid)  stat <= STAT_INS;
              else begin
                stat    <= STAT_HLT;
                retired <= retired + CNT_W'(1);
              end
            end else begin
              icode_q   <= icode;
              state     <= S_DECODE;
              decode_en <= 1'b1;
            end
          end else if (tmo) begin
            imem_req <= 1'b0;
            state    <= S_HALT;
            stat     <= STAT_ADR;
            busy     <= 1'b0;
          end
        end
        S_DECODE: begin
          decode_en <= 1'b0;
          exec_en   <= 1'b1;
          state     <= S_EXECUTE;
        end
        S_EXECUTE: begin
          exec_en <= 1'b0;
          if (needs_mem(icode_q)) begin
            state    <= S_MEMORY;
            dmem_req <= 1'b1;
          end else begin
            state <= S_WRITEBACK;
            wb_en <= 1'b1;
          end
        end
        S_MEMORY: begin
          if ((dmem_ack && dmem_err) || (!dmem_ack && tmo)) begin
            dmem_req <= 1'b0;
            state    <= S_HALT;
            stat     <= STAT_ADR;
            busy     <= 1'b0;
          end else if (dmem_ack) begin
            dmem_req <= 1'b0;
            state    <= S_WRITEBACK;
            wb_en    <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          wb_en <= 1'b0;
          pc_we <= 1'b1;
          state <= S_PCUPD;
        end
        S_PCUPD: begin
          pc_we    <= 1'b0;
          retired  <= retired + CNT_W'(1);
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Bench for y86_seq_ctrl: per-instruction cycle plans (waits, faults, stray
// acks) expanded into expected per-cycle outputs and compared every cycle.
module tb_y86_seq_ctrl;
  localparam int TMO = 4;
  localparam int CW  = 4;

  // Output vector order: imem_req, dmem_req, decode_en, exec_en, wb_en, pc_we, busy
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_FE   = 7'b1000001;
  localparam logic [6:0] O_DE   = 7'b0010001;
  localparam logic [6:0] O_EX   = 7'b0001001;
  localparam logic [6:0] O_ME   = 7'b0100001;
  localparam logic [6:0] O_WB   = 7'b0000101;
  localparam logic [6:0] O_PC   = 7'b0000011;

  logic          clk = 1'b0;
  logic          rst_n, start, imem_ack, imem_err, instr_valid, dmem_ack, dmem_err;
  logic [3:0]    icode;
  logic          imem_req, dmem_req, decode_en, exec_en, wb_en, pc_we, busy;
  logic [2:0]    stat;
  logic [CW-1:0] retired;
  logic [6:0]    outs;

  assign outs = {imem_req, dmem_req, decode_en, exec_en, wb_en, pc_we, busy};

  y86_seq_ctrl #(.CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_err(imem_err),
    .icode(icode), .instr_valid(instr_valid),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
    .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en), .pc_we(pc_we),
    .stat(stat), .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]    o;
    bit            go, ia, da;
    logic [3:0]    ic;
    bit            iv, ie, de;
    logic [2:0]    st;
    logic [CW-1:0] rt;
  } step_t;

  step_t         q[$];
  int            checks = 0;
  int            errors = 0;
  logic [2:0]    m_stat;
  logic [CW-1:0] m_ret;
  logic [3:0]    c_ic;
  bit            c_iv, c_ie, c_de;
  logic [3:0]    memops[6] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] o, input bit go, input bit ia, input bit da);
    step_t s;
    s.o = o; s.go = go; s.ia = ia; s.da = da;
    s.ic = c_ic; s.iv = c_iv; s.ie = c_ie; s.de = c_de;
    s.st = m_stat; s.rt = m_ret;
    q.push_back(s);
  endtask

  // Expand one instruction into its expected cycles; iw/dw >= TMO means no ack.
  task automatic plan(input logic [3:0] ic, input bit iv, input bit ie,
                      input int iw, input bit de, input int dw);
    int n;
    c_ic = ic; c_iv = iv; c_ie = ie; c_de = de;
    n = (iw >= TMO) ? TMO : iw + 1;
    for (int c = 1; c <= n; c++) push(O_FE, 1'b0, (iw < TMO) && (c == n), 1'b0);
    if (iw >= TMO || ie) begin m_stat = 3'd3; return; end
    if (!iv)             begin m_stat = 3'd4; return; end
    if (ic == 4'h0)      begin m_stat = 3'd2; m_ret++; return; end
    push(O_DE, 1'b0, 1'b0, 1'b0);
    push(O_EX, 1'b0, 1'b0, 1'b0);
    if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
      n = (dw >= TMO) ? TMO : dw + 1;
      for (int c = 1; c <= n; c++) push(O_ME, 1'b0, 1'b0, (dw < TMO) && (c == n));
      if (dw >= TMO || de) begin m_stat = 3'd3; return; end
    end
    push(O_WB, 1'b0, 1'b0, 1'b0);
    push(O_PC, 1'b0, 1'b0, 1'b0);
    m_ret++;
  endtask

  task automatic play();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      chk("outs", 32'(outs), 32'(s.o));
      chk("stat", 32'(stat), 32'(s.st));
      chk("retired", 32'(retired), 32'(s.rt));
      start       = s.go;
      icode       = s.ic;
      instr_valid = s.iv;
      imem_err    = s.ie;
      dmem_err    = s.de;
      imem_ack    = (s.o == O_FE) ? s.ia : 1'($urandom_range(0, 1));
      dmem_ack    = (s.o == O_ME) ? s.da : 1'($urandom_range(0, 1));
    end
  endtask

  // Once halted, nothing but reset may move the block.
  task automatic halt_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("halt_outs", 32'(outs), 32'(O_IDLE));
      chk("halt_stat", 32'(stat), 32'(m_stat));
      chk("halt_retired", 32'(retired), 32'(m_ret));
      start    = 1'b1;
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      icode    = 4'($urandom_range(1, 11));
      instr_valid = 1'b1;
      imem_err = 1'b0;
      dmem_err = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; imem_ack = 1'b0; imem_err = 1'b0; instr_valid = 1'b0;
    dmem_ack = 1'b0; dmem_err = 1'b0; icode = 4'h0;
    #1;
    chk("rst_outs", 32'(outs), 32'(O_IDLE));
    chk("rst_stat", 32'(stat), 32'd1);
    chk("rst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_stat = 3'd1;
    m_ret  = '0;
  endtask

  task automatic go_start();
    c_ic = 4'h0; c_iv = 1'b0; c_ie = 1'b0; c_de = 1'b0;
    push(O_IDLE, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, kind;
    logic [3:0] mop;
    rst_n = 1'b0;
    start = 1'b0; imem_ack = 1'b0; imem_err = 1'b0; instr_valid = 1'b0;
    dmem_ack = 1'b0; dmem_err = 1'b0; icode = 4'h0;
    m_stat = 3'd1; m_ret = '0;

    // OPq zero-wait, then halt
    do_reset(); go_start();
    plan(4'h6, 1, 0, 0, 0, 0);
    plan(4'h0, 1, 0, 0, 0, 0);
    play(); halt_check(2);

    // mrmovq with 3 dmem wait cycles, then halt
    do_reset(); go_start();
    plan(4'h5, 1, 0, 0, 0, 3);
    plan(4'h0, 1, 0, 1, 0, 0);
    play(); halt_check(2);

    // halt on first instruction; later start pulses and acks ignored
    do_reset(); go_start();
    plan(4'h0, 1, 0, 0, 0, 0);
    play(); halt_check(4);

    // invalid instruction after a good one
    do_reset(); go_start();
    plan(4'h2, 1, 0, 2, 0, 0);
    plan(4'h3, 0, 0, 0, 0, 0);
    play(); halt_check(2);

    // pushq with dmem error
    do_reset(); go_start();
    plan(4'hA, 1, 0, 0, 1, 0);
    play(); halt_check(2);

    // fetch timeout, and dmem timeout
    do_reset(); go_start();
    plan(4'h6, 1, 0, TMO, 0, 0);
    play(); halt_check(2);
    do_reset(); go_start();
    plan(4'h8, 1, 0, 0, 0, TMO);
    play(); halt_check(2);

    // reset while in MEMORY, dmem_ack arrives after release
    do_reset(); go_start();
    plan(4'h1, 1, 0, 0, 0, 0);
    c_ic = 4'h5; c_iv = 1'b1; c_ie = 1'b0; c_de = 1'b0;
    push(O_FE, 0, 1, 0); push(O_DE, 0, 0, 0); push(O_EX, 0, 0, 0); push(O_ME, 0, 0, 0);
    play();
    @(negedge clk);
    rst_n = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b0;
    #1;
    chk("midrst_outs", 32'(outs), 32'(O_IDLE));
    chk("midrst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_err = 1'b0; start = 1'b0;
    m_stat = 3'd1; m_ret = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("postrst_outs", 32'(outs), 32'(O_IDLE));
      chk("postrst_stat", 32'(stat), 32'd1);
      chk("postrst_retired", 32'(retired), 32'd0);
    end

    // Random programs; the first is long enough to wrap the counter
    for (int p = 0; p < 5; p++) begin
      do_reset(); go_start();
      n = (p == 0) ? 18 : $urandom_range(0, 6);
      for (int i = 0; i < n; i++)
        plan(4'($urandom_range(1, 11)), 1, 0, $urandom_range(0, TMO - 1), 0,
             $urandom_range(0, TMO - 1));
      kind = $urandom_range(0, 5);
      mop  = memops[$urandom_range(0, 5)];
      case (kind)
        0: plan(4'h0, 1, 0, $urandom_range(0, TMO - 1), 0, 0);
        1: plan(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1, $urandom_range(0, TMO - 1), 0, 0);
        2: plan(4'($urandom_range(0, 15)), 0, 0, $urandom_range(0, TMO - 1), 0, 0);
        3: plan(4'($urandom_range(0, 15)), 1, 0, TMO, 0, 0);
        4: plan(mop, 1, 0, 0, 1, $urandom_range(0, TMO - 1));
        default: plan(mop, 1, 0, 0, 0, TMO);
      endcase
      play(); halt_check(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_seq_ctrl.md
Name: y86_seq_ctrl

Overview:
- Multi-cycle stage sequencer for the Y86-64 sequential core.
- Walks each instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, and owns the imem/dmem request handshakes.
- Issues one-cycle stage enables; pc_we gates the PC register write in the PC-update stage.
- Tracks architectural status (AOK/HLT/ADR/INS) and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT, 16, max cycles waiting for imem_ack/dmem_ack before ADR fault (>=1)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; begin/continue execution when in IDLE
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete; icode/instr_valid valid this cycle
- imem_err  in  1  fetch address error, qualified by imem_ack
- icode  in  4  opcode from fetch, sampled on imem_ack
- instr_valid  in  1  fetch decoded a legal instruction, sampled on imem_ack
- dmem_req  out  1  data memory request
- dmem_ack  in  1  data access complete
- dmem_err  in  1  data address error, qualified by dmem_ack
- decode_en  out  1  one-cycle decode/register-read enable
- exec_en  out  1  one-cycle ALU/CC enable
- wb_en  out  1  one-cycle register-file write enable
- pc_we  out  1  one-cycle PC register write enable
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  out  1  high in any state except IDLE, HALT
- retired  out  CNT_W  instructions retired since reset

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, stat=1 (AOK), retired=0.
  - All req/enables 0, busy=0.
  - Takes effect mid-handshake; any outstanding ack after reset release is ignored.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- IDLE: start=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1 every cycle in state; ack may arrive the same cycle (zero-wait).
  - On ack, priority order:
    - imem_err -> HALT, stat=ADR.
    - else !instr_valid -> HALT, stat=INS.
    - else icode=0 (halt) -> HALT, stat=HLT, retired+1.
    - else latch icode, go to DECODE.
  - No ack within TIMEOUT cycles (counted from the first req cycle) -> HALT, stat=ADR.
- DECODE: decode_en=1 for one cycle -> EXECUTE.
- EXECUTE: exec_en=1 for one cycle.
  - Latched icode in {4,5,8,9,A,B} -> MEMORY.
  - Otherwise -> WRITEBACK.
- MEMORY:
  - dmem_req=1 until ack; same ack/err/TIMEOUT rules as FETCH.
  - Error or timeout -> HALT, stat=ADR, no wb_en/pc_we issued.
  - ack without error -> WRITEBACK.
- WRITEBACK: wb_en=1 one cycle -> PCUPD.
- PCUPD: pc_we=1 one cycle, retired increments, -> FETCH. start is not re-sampled.
- HALT: sticky; stat holds. Only rst_n exits.
- Latency with zero-wait memory:
  - Non-memory instruction: 5 cycles FETCH->PCUPD inclusive.
  - Memory instruction: 6 cycles.
  - Each wait cycle adds 1.
- retired wraps modulo 2^CNT_W, no saturation.
- Stray imem_ack/dmem_ack outside the matching state is ignored.
- Enables are mutually exclusive; at most one of decode_en/exec_en/wb_en/pc_we is high in any cycle.
- Timeout counter clears on every state entry.

Decomposition:
- Shared package y86_pkg:
  - stat codes STAT_AOK/HLT/ADR/INS.
  - icode constants (I_HALT=0 … I_POPQ=B).
  - State enum for y86_seq_ctrl.
- Sub-module y86_ack_timer:
  - Loadable down-counter of width clog2(TIMEOUT+1) with a timeout flag.
  - Shared by FETCH and MEMORY waits.

Test Plan:
- Reset then start=1, icode=6 (OPq), zero-wait imem_ack -> decode_en, exec_en, wb_en, pc_we on cycles 2..5 after FETCH entry; retired=1; no dmem_req.
- icode=5 (mrmovq), dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, pc_we on cycle 9 after FETCH entry; retired=1.
- icode=0 -> HALT, stat=2, busy=0, retired=1; later start pulses and acks do not change anything.
- instr_valid=0 on fetch ack -> stat=4, no decode_en; dmem_err on icode=A (pushq) -> stat=3, no wb_en/pc_we.
- TIMEOUT=4, imem_ack never asserted -> imem_req high exactly 4 cycles, then stat=3 HALT.
- rst_n asserted during MEMORY with dmem_ack arriving one cycle after release -> state IDLE, stat=1, retired=0, ack ignored.
